// File: rtl/qmod_pkg.sv
//==============================================================================
// Module      : qmod_pkg
// Description : Shared state encoding and result codes for the serial
//               magnitude comparator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package qmod_pkg;

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        RESULT = 1'b1
    } state_t;

    // Result codes, laid out as {gt, eq, lt}
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

endpackage : qmod_pkg

`default_nettype wire

// File: rtl/greater_than.sv
//==============================================================================
// Module      : greater_than
// Description : Single-bit unsigned greater-than stage (gt = a > b).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module greater_than (
    input  logic a,
    input  logic b,
    output logic gt
);

    assign gt = a & ~b;

endmodule : greater_than

`default_nettype wire

// File: rtl/serial_greater_than_bitcmp.sv
//==============================================================================
// Module      : serial_greater_than_bitcmp
// Description : Per-bit decision terms: whether the operand bits differ and,
//               if they do, whether A is the larger one.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_greater_than_bitcmp (
    input  logic a_i,
    input  logic b_i,
    output logic differ_o,
    output logic a_wins_o
);

    logic w_a_gt_b;
    logic w_b_gt_a;

    greater_than u_gt_ab (
        .a  (a_i),
        .b  (b_i),
        .gt (w_a_gt_b)
    );

    greater_than u_gt_ba (
        .a  (b_i),
        .b  (a_i),
        .gt (w_b_gt_a)
    );

    assign differ_o = w_a_gt_b | w_b_gt_a;
    assign a_wins_o = w_a_gt_b;

endmodule : serial_greater_than_bitcmp

`default_nettype wire

// File: rtl/serial_greater_than.sv
//==============================================================================
// Module      : serial_greater_than
// Description : Bit-serial MSB-first unsigned magnitude comparator with
//               valid/ready handshakes on the bit input and the result output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_greater_than
    import qmod_pkg::*;
#(
    parameter int MAX_BITS = 32,
    parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_eq,
    output logic             out_lt,
    output logic [CNT_W-1:0] out_nbits,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BITS);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_gt_q;
    logic             out_eq_q;
    logic             out_lt_q;
    logic [CNT_W-1:0] out_nbits_q;
    logic             out_ovf_q;
    logic             decided_q;
    logic             gt_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic             decided_d;
    logic             gt_d;
    logic [CNT_W-1:0] count_d;
    logic             ovf_d;
    logic             w_accept;
    logic             w_differ;
    logic             w_a_wins;
    logic             w_count_full;

    serial_greater_than_bitcmp u_bitcmp (
        .a_i      (in_a),
        .b_i      (in_b),
        .differ_o (w_differ),
        .a_wins_o (w_a_wins)
    );

    assign w_accept     = in_valid & in_ready_q;
    assign w_count_full = (count_q == C_MAX);

    // Values after absorbing the current beat; the first differing bit wins.
    always_comb begin
        decided_d = decided_q;
        gt_d      = gt_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (w_accept) begin
            if (!decided_q && w_differ) begin
                decided_d = 1'b1;
                gt_d      = w_a_wins;
            end
            if (w_count_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_gt_q    <= 1'b0;
            out_eq_q    <= 1'b0;
            out_lt_q    <= 1'b0;
            out_nbits_q <= '0;
            out_ovf_q   <= 1'b0;
            decided_q   <= 1'b0;
            gt_q        <= 1'b0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    decided_q <= decided_d;
                    gt_q      <= gt_d;
                    count_q   <= count_d;
                    ovf_q     <= ovf_d;
                    if (w_accept && in_last) begin
                        state_q     <= RESULT;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_gt_q    <= decided_d & gt_d;
                        out_lt_q    <= decided_d & ~gt_d;
                        out_eq_q    <= ~decided_d;
                        out_nbits_q <= count_d;
                        out_ovf_q   <= ovf_d;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_q     <= SCAN;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_gt_q    <= 1'b0;
                        out_eq_q    <= 1'b0;
                        out_lt_q    <= 1'b0;
                        out_nbits_q <= '0;
                        out_ovf_q   <= 1'b0;
                        decided_q   <= 1'b0;
                        gt_q        <= 1'b0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_gt    = out_gt_q;
    assign out_eq    = out_eq_q;
    assign out_lt    = out_lt_q;
    assign out_nbits = out_nbits_q;
    assign out_ovf   = out_ovf_q;

endmodule : serial_greater_than

`default_nettype wire

// File: tb/tb_serial_greater_than.sv
//==============================================================================
// Module      : tb_serial_greater_than
// Description : Randomized self-checking bench for serial_greater_than with an
//               integer-compare reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_greater_than;

    localparam int MAX_BITS = 4;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_a;
    logic             in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_gt;
    logic             out_eq;
    logic             out_lt;
    logic [CNT_W-1:0] out_nbits;
    logic             out_ovf;

    int n_vec;
    int n_err;

    serial_greater_than #(
        .MAX_BITS (MAX_BITS)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gt    (out_gt),
        .out_eq    (out_eq),
        .out_lt    (out_lt),
        .out_nbits (out_nbits),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [2:0] exp_code,
                                input int exp_nbits, input logic exp_ovf);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " gt/eq/lt"}, 32'({out_gt, out_eq, out_lt}), 32'(exp_code));
        check({tag, " nbits"}, 32'(out_nbits), 32'(exp_nbits));
        check({tag, " ovf"}, 32'(out_ovf), 32'(exp_ovf));
    endtask

    // Sends an n-bit word MSB first and checks the result against the integer model.
    task automatic send_word(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input int n, input int gap, input int hold);
        logic [15:0] mask;
        logic [2:0]  exp_code;
        int          exp_nbits;
        logic        exp_ovf;
        mask      = 16'((32'd1 << n) - 1);
        exp_code  = ((a & mask) > (b & mask)) ? 3'b100 :
                    ((a & mask) < (b & mask)) ? 3'b001 : 3'b010;
        exp_nbits = (n > MAX_BITS) ? MAX_BITS : n;
        exp_ovf   = (n > MAX_BITS);
        for (int i = n - 1; i >= 0; i--) begin
            repeat (gap) begin
                in_valid = 1'b0;
                in_a     = 1'($urandom);
                in_b     = 1'($urandom);
                @(posedge clk); #1;
                check({tag, " bubble valid"}, 32'(out_valid), 32'd0);
            end
            check({tag, " beat ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_a     = a[i];
            in_b     = b[i];
            in_last  = (i == 0);
            @(posedge clk); #1;
            if (i != 0) check({tag, " early valid"}, 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result(tag, exp_code, exp_nbits, exp_ovf);
        // A beat offered during RESULT must not be absorbed.
        for (int h = 0; h < hold; h++) begin
            in_valid  = 1'b1;
            in_a      = 1'b1;
            in_b      = 1'b0;
            in_last   = 1'b1;
            out_ready = 1'b0;
            @(posedge clk); #1;
            check_result({tag, " hold"}, exp_code, exp_nbits, exp_ovf);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post valid"}, 32'(out_valid), 32'd0);
        check({tag, " post ready"}, 32'(in_ready), 32'd1);
        check({tag, " post flags"}, 32'({out_gt, out_eq, out_lt, out_ovf}), 32'd0);
        check({tag, " post nbits"}, 32'(out_nbits), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(in_ready), 32'd1);
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset flags", 32'({out_gt, out_eq, out_lt, out_ovf}), 32'd0);
        check("reset nbits", 32'(out_nbits), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_word("t1011", 16'b1011, 16'b1001, 4, 0, 0);
        send_word("t5a", 16'h5A, 16'h5A, 8, 0, 3);
        send_word("t1b10", 16'd1, 16'd0, 1, 0, 0);
        send_word("t1b01", 16'd0, 16'd1, 1, 0, 0);
        send_word("t1b11", 16'd1, 16'd1, 1, 0, 0);
        send_word("t1b00", 16'd0, 16'd0, 1, 0, 0);
        send_word("tbubble", 16'b0111, 16'b1000, 4, 1, 0);
        send_word("tovf", 16'b000001, 16'b000000, 6, 0, 0);
        send_word("tnoovf", 16'b10, 16'b11, 2, 0, 0);

        // Asynchronous reset mid-word, between clock edges.
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        in_a = 1'b0; in_b = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst valid", 32'(out_valid), 32'd0);
        check("arst ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        send_word("tafter", 16'b100, 16'b011, 3, 0, 0);

        // Asynchronous reset while a result is pending.
        in_valid = 1'b1; in_a = 1'b1; in_b = 1'b0; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("pend valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rrst valid", 32'(out_valid), 32'd0);
        check("rrst ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 40; k++) begin
            send_word("rand", 16'($urandom), 16'($urandom), $urandom_range(1, 8),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end
        // Equal operands are rare at random; force a few.
        for (int k = 0; k < 5; k++) begin
            logic [15:0] v;
            v = 16'($urandom);
            send_word("randeq", v, v, $urandom_range(1, 8), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_greater_than

`default_nettype wire

// File: doc/serial_greater_than.md
Name: serial_greater_than

Overview:
- Bit-serial magnitude comparator that consumes two unsigned operands MSB-first, one bit pair per beat, and reports greater/equal/less once the word ends.
- Serial receiving counterpart of the single-bit greater_than stage; extends that per-bit decision to arbitrary-length words.
- Input and result use valid/ready handshakes so the block drops into the pipeline between a serialising source and a result consumer.

Parameters:
- MAX_BITS, 32: longest word counted without overflow; a longer word still compares correctly but sets out_ovf.
- CNT_W, $clog2(MAX_BITS+1): width of the bit counter and of out_nbits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  bit pair on in_a/in_b is valid.
- in_ready  output  1  block accepts a bit pair this cycle.
- in_a  input  1  operand A bit, MSB first.
- in_b  input  1  operand B bit, MSB first.
- in_last  input  1  this beat carries the LSB (final bit) of the word.
- out_valid  output  1  comparison result is valid.
- out_ready  input  1  consumer accepts the result.
- out_gt  output  1  A > B.
- out_eq  output  1  A == B.
- out_lt  output  1  A < B.
- out_nbits  output  CNT_W  number of bits in the word, saturating at MAX_BITS.
- out_ovf  output  1  word was longer than MAX_BITS.

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: state = SCAN, in_ready = 1, out_valid = 0, out_gt = out_eq = out_lt = 0, out_nbits = 0, out_ovf = 0, decided = 0, count = 0.
- A beat is accepted when in_valid & in_ready.
- States:
  - SCAN: in_ready = 1, out_valid = 0.
  - RESULT: in_ready = 0, out_valid = 1.
- SCAN, on each accepted beat:
  - count increments, saturating at MAX_BITS; ovf is set if count is already MAX_BITS when another beat is accepted.
  - If decided = 0 and in_a != in_b: decided <= 1, gt_r <= in_a (in_a = 1, in_b = 0 gives gt; the reverse gives lt).
  - If decided = 1, later bits are consumed and ignored.
  - If in_last: go to RESULT next cycle.
- Result encoding in RESULT:
  - decided = 1: out_gt = gt_r, out_lt = ~gt_r, out_eq = 0.
  - decided = 0: out_eq = 1, out_gt = out_lt = 0.
  - Exactly one of out_gt/out_eq/out_lt is 1 whenever out_valid = 1.
  - out_nbits includes the last beat.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- RESULT:
  - All outputs are held stable until out_valid & out_ready.
  - On that cycle: go to SCAN; clear decided, gt_r, count and ovf; outputs go to 0.
  - in_ready returns to 1 the cycle after the handshake, so there is no same-cycle pass-through and the minimum word period is N+1 cycles.
- in_valid = 0 in SCAN: state is held; bubbles between bits are legal.
- in_last on the first beat: a 1-bit word; the result equals greater_than(a, b).
- An in_valid beat presented during RESULT is not accepted; the source must hold it.
- Reset mid-word or while in RESULT: the partial word and any pending result are discarded immediately; the source restarts with a fresh word.
- A word longer than MAX_BITS still compares correctly; out_nbits = MAX_BITS and out_ovf = 1.

Decomposition:
- Shared package (qmod_pkg):
  - state enum {SCAN, RESULT}.
  - CMP_GT/CMP_EQ/CMP_LT result-code localparams for benches.
- Sub-module: bit-decision logic instantiates the existing greater_than twice:
  - greater_than(a, b) gives in_a > in_b.
  - greater_than(b, a) gives in_b > in_a.
  - These generate the "differ" and "direction" terms.
- The FSM, counter and result registers stay in serial_greater_than.

Test Plan:
- A = 1011, B = 1001 MSB-first, in_valid held 1, out_ready = 1 → decision on bit 1; after beat 4, out_valid for one cycle with gt = 1, eq = 0, lt = 0, nbits = 4.
- A = B = 0x5A (8 bits), out_ready held 0 for 3 cycles → eq = 1, nbits = 8; result stable for 4 cycles; in_ready = 0 throughout; SCAN on the cycle after the handshake.
- 1-bit words (a, b) = (1,0), (0,1), (1,1), (0,0) back-to-back → gt, lt, eq, eq; in_ready low exactly one cycle after each word.
- A = 0111, B = 1000 with in_valid bubbles between every beat → lt = 1 (decided on the MSB), nbits = 4; bubbles do not change the result.
- MAX_BITS = 4, 6-bit word A = 000001, B = 000000 → gt = 1, nbits = 4, ovf = 1; the next word reports ovf = 0.
- Reset pulse asynchronously after beat 2 of a word → out_valid = 0 and in_ready = 1 immediately; a following 3-bit word 100 vs 011 reports gt = 1, nbits = 3 with no residue from the aborted word.
